// File: rtl/ahb_pkg.sv
// ----------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite types and constants for the register slave and its regfile.
//   htrans_e    : transfer type encoding (IDLE/BUSY/NONSEQ/SEQ)
//   hresp_e     : response encoding (OKAY/ERROR/RETRY/SPLIT)
//   slv_state_e : slave protocol FSM states
//   AHB_DW      : bus data width
// ----------------------------------------------------------------------------
package ahb_pkg;

    localparam int AHB_DW = 32;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    typedef enum logic [2:0] {
        SLV_IDLE = 3'd0,
        SLV_WAIT = 3'd1,
        SLV_LAST = 3'd2,
        SLV_ERR1 = 3'd3,
        SLV_ERR2 = 3'd4
    } slv_state_e;

endpackage

// File: rtl/ahb_slv_regfile.sv
// ----------------------------------------------------------------------------
// ahb_slv_regfile
// Word register array behind the AHB slave. One write port, one combinational
// read port; a read that targets the index being written this cycle returns
// the incoming write data instead of the stale array contents.
// Ports:
//   clk_i     : clock (rising edge)
//   rst_i     : asynchronous active-high reset, loads RST_VAL everywhere
//   we_i      : write enable, commits on the next rising edge
//   wr_idx_i  : write word index
//   wdata_i   : write data
//   rd_idx_i  : read word index
//   rd_data_o : read data (zero for an out-of-range index)
// ----------------------------------------------------------------------------
module ahb_slv_regfile
    import ahb_pkg::*;
#(
    parameter int                NUM_REGS = 16,
    parameter logic [AHB_DW-1:0] RST_VAL  = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [7:0]        wr_idx_i,
    input  logic [AHB_DW-1:0] wdata_i,
    input  logic [7:0]        rd_idx_i,
    output logic [AHB_DW-1:0] rd_data_o
);

    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [AHB_DW-1:0] mem_q [NUM_REGS];
    logic              wr_ok_s;
    logic              rd_ok_s;
    logic [IW-1:0]     wr_sel_s;
    logic [IW-1:0]     rd_sel_s;

    // Range checks happen on the full 8-bit index before narrowing to the array index.
    assign wr_ok_s  = ({1'b0, wr_idx_i} < 9'(NUM_REGS));
    assign rd_ok_s  = ({1'b0, rd_idx_i} < 9'(NUM_REGS));
    assign wr_sel_s = wr_idx_i[IW-1:0];
    assign rd_sel_s = rd_idx_i[IW-1:0];

    // Register array: reset to RST_VAL, single write port.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= RST_VAL;
            end
        end else if (we_i && wr_ok_s) begin
            mem_q[wr_sel_s] <= wdata_i;
        end
    end

    // Read port with same-cycle write forwarding.
    always_comb begin
        rd_data_o = {AHB_DW{1'b0}};
        if (!rd_ok_s) begin
            rd_data_o = {AHB_DW{1'b0}};
        end else if (we_i && wr_ok_s && (wr_idx_i == rd_idx_i)) begin
            rd_data_o = wdata_i;
        end else begin
            rd_data_o = mem_q[rd_sel_s];
        end
    end

endmodule

// File: rtl/ahb_reg_slave.sv
// ----------------------------------------------------------------------------
// ahb_reg_slave
// AHB-Lite slave backed by a word-addressed register bank. Every OKAY data
// phase carries WAIT_CNT wait states; bad accesses get a two-cycle ERROR.
// This is the only slave on the bus, so its own hready is the bus hready.
// Ports:
//   hclk   : bus clock, rising edge
//   hrst   : asynchronous active-high reset
//   hsel   : slave select
//   haddr  : byte address, bits [9:2] are the word index
//   htrans : transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   hwrite : 1 = write, 0 = read
//   hprot  : protection bits, only used with AHB_SLV_PROT_CHK_EN
//   hwdata : write data, sampled in the last data-phase cycle
//   hrdata : registered read data, zero outside a read's last cycle
//   hready : registered transfer-done / ready
//   hresp  : registered response (OKAY / ERROR)
// Build option:
//   AHB_SLV_PROT_CHK_EN : user-mode (hprot[1]=0) access to index 0 is an error.
// ----------------------------------------------------------------------------
module ahb_reg_slave
    import ahb_pkg::*;
#(
    parameter int                NUM_REGS = 16,
    parameter int                WAIT_CNT = 2,
    parameter logic [AHB_DW-1:0] RST_VAL  = 32'h0000_0000
) (
    input  logic              hclk,
    input  logic              hrst,
    input  logic              hsel,
    input  logic [31:0]       haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [3:0]        hprot,
    input  logic [AHB_DW-1:0] hwdata,
    output logic [AHB_DW-1:0] hrdata,
    output logic              hready,
    output logic [1:0]        hresp
);

    // Last value of the wait counter before moving on to LAST.
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CNT - 1);

    slv_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [7:0]        idx_q, idx_d;
    logic [AHB_DW-1:0] hrdata_q, hrdata_d;
    logic              hready_q, hready_d;
    hresp_e            hresp_q, hresp_d;

    logic [7:0]        addr_idx_s;
    logic              accept_s;
    logic              addr_err_s;
    logic              prot_err_s;
    logic              err_s;
    logic [7:0]        rd_idx_s;
    logic              we_s;
    logic [AHB_DW-1:0] rd_data_s;
    logic              unused_s;

    assign addr_idx_s = haddr[9:2];
    assign accept_s   = hsel && htrans[1] && hready_q;
    assign addr_err_s = (haddr[1:0] != 2'b00) || ({1'b0, addr_idx_s} >= 9'(NUM_REGS));
`ifdef AHB_SLV_PROT_CHK_EN
    assign prot_err_s = (addr_idx_s == 8'd0) && !hprot[1];
`else
    assign prot_err_s = 1'b0;
`endif
    assign err_s      = addr_err_s || prot_err_s;
    assign unused_s   = &{1'b0, haddr[31:10], hprot};

    // A read entering LAST straight from an address phase uses the live index;
    // one coming out of WAIT uses the latched index.
    assign rd_idx_s = accept_s ? addr_idx_s : idx_q;
    // Writes commit on the edge that ends LAST, with hwdata of that cycle.
    assign we_s     = (state_q == SLV_LAST) && write_q;

    ahb_slv_regfile #(
        .NUM_REGS (NUM_REGS),
        .RST_VAL  (RST_VAL)
    ) u_regfile (
        .clk_i     (hclk),
        .rst_i     (hrst),
        .we_i      (we_s),
        .wr_idx_i  (idx_q),
        .wdata_i   (hwdata),
        .rd_idx_i  (rd_idx_s),
        .rd_data_o (rd_data_s)
    );

    // Protocol FSM next-state, wait counter and address-phase capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        idx_d   = idx_q;
        case (state_q)
            SLV_WAIT: begin
                if (cnt_q >= WAIT_LAST) begin
                    state_d = SLV_LAST;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            SLV_ERR1: begin
                state_d = SLV_ERR2;
            end
            // hready is high in these states, so a new address phase may land here.
            SLV_IDLE, SLV_LAST, SLV_ERR2: begin
                if (accept_s) begin
                    write_d = hwrite;
                    idx_d   = addr_idx_s;
                    cnt_d   = 4'd0;
                    if (err_s) begin
                        state_d = SLV_ERR1;
                    end else if (WAIT_CNT > 0) begin
                        state_d = SLV_WAIT;
                    end else begin
                        state_d = SLV_LAST;
                    end
                end else begin
                    state_d = SLV_IDLE;
                end
            end
            default: begin
                state_d = SLV_IDLE;
            end
        endcase
    end

    // Bus outputs are derived from the next state so they can be registered.
    always_comb begin
        hready_d = (state_d != SLV_WAIT) && (state_d != SLV_ERR1);
        if ((state_d == SLV_ERR1) || (state_d == SLV_ERR2)) begin
            hresp_d = HRESP_ERROR;
        end else begin
            hresp_d = HRESP_OKAY;
        end
        if ((state_d == SLV_LAST) && !write_d) begin
            hrdata_d = rd_data_s;
        end else begin
            hrdata_d = {AHB_DW{1'b0}};
        end
    end

    // State and output registers.
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            state_q  <= SLV_IDLE;
            cnt_q    <= 4'd0;
            write_q  <= 1'b0;
            idx_q    <= 8'd0;
            hrdata_q <= {AHB_DW{1'b0}};
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            idx_q    <= idx_d;
            hrdata_q <= hrdata_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
        end
    end

    assign hrdata = hrdata_q;
    assign hready = hready_q;
    assign hresp  = hresp_q;

endmodule

// File: doc/ahb_reg_slave.md
Name: ahb_reg_slave

Overview:
- AHB-Lite slave that consumes the master-side bus signals (haddr, hprot, hsel, htrans, hwdata, hwrite) and produces the slave response (hrdata, hready, hresp).
- Backs the bus with a word-addressed register bank, programmable wait states and two-cycle ERROR responses.
- Acts as the DUT-side endpoint of the AHB bus in the block-level environment.
- Single slave on the bus: its own hready is the bus hready.

Parameters:
NUM_REGS, 16, number of 32-bit registers; legal word index 0..NUM_REGS-1 (2..256)
WAIT_CNT, 2, wait cycles (hready low) inserted in every OKAY data phase (0..15)
RST_VAL, 32'h0, reset value of every register

Ports:
hclk  input  1  bus clock, all logic on rising edge
hrst  input  1  asynchronous, active-high reset
hsel  input  1  slave select
haddr  input  32  byte address; offset bits [9:2] form the word index
htrans  input  2  IDLE/BUSY/NONSEQ/SEQ
hwrite  input  1  1 = write, 0 = read
hprot  input  4  protection; used only with the optional feature
hwdata  input  32  write data, valid in the data phase
hrdata  output  32  read data, registered
hready  output  1  transfer done / slave ready, registered
hresp  output  2  00 OKAY, 01 ERROR, registered

Behaviour:
- Reset:
  - Outputs: hrdata=0, hready=1, hresp=OKAY, state IDLE, wait counter 0.
  - All registers load RST_VAL.
  - Reset asserted mid-transfer discards the pending transfer. No write is committed.
- Valid address phase: hsel & htrans[1] & hready, sampled on the hclk edge. The slave latches hwrite, index and error flag.
- Error flag is set when haddr[1:0]!=0 or index>=NUM_REGS.
- htrans IDLE/BUSY, or hsel=0: no transfer; OKAY with hready=1.
- States:
  - IDLE: hready=1, OKAY.
    - Accept without error and WAIT_CNT>0 -> WAIT.
    - Accept without error and WAIT_CNT=0 -> LAST.
    - Accept with error -> ERR1.
  - WAIT: hready=0, OKAY. Counter counts WAIT_CNT cycles, then -> LAST.
  - LAST: hready=1, OKAY.
    - Read: hrdata = reg[index].
    - Write: reg[index] <= hwdata on the edge ending LAST.
    - A new valid address phase in this cycle (back-to-back) branches as from IDLE; otherwise -> IDLE.
  - ERR1: hready=0, hresp=ERROR -> ERR2.
  - ERR2: hready=1, hresp=ERROR. No register write; hrdata=0. New address phase accepted as from IDLE.
- Latency:
  - OKAY transfer: data phase lasts WAIT_CNT+1 cycles.
  - Error transfer: always 2 cycles.
- hrdata:
  - Loaded on entry to LAST for reads.
  - Zero in all other cycles.
- Read-after-write forwarding: a read entering LAST on the same edge that commits a write to the same index returns the new hwdata, not the old value.
- Write-data sampling: hwdata is sampled only in LAST; values in WAIT cycles are ignored.
- Wait counter: width 4 bits; reloads on every accept; never wraps.
- SEQ is handled identically to NONSEQ; there is no burst-boundary check.

Optional Feature:
- Macro: AHB_SLV_PROT_CHK_EN.
- Defined: an access with hprot[1]=0 (user) to index 0 (the privileged control register) sets the error flag. Result is a two-cycle ERROR and no write.
- Undefined: hprot is ignored and the port stays connected but unused.

Decomposition:
- Shared package ahb_pkg:
  - htrans_e: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
  - hresp_e: OKAY=00, ERROR=01, RETRY=10, SPLIT=11.
  - slv_state_e: IDLE, WAIT, LAST, ERR1, ERR2.
  - Constant AHB_DW=32.
- One sub-module, ahb_slv_regfile: register array with write port, read port, same-cycle forwarding and RST_VAL reset.
- Protocol FSM stays in ahb_reg_slave.

Test Plan:
- Reset: assert hrst for 3 cycles mid-WAIT of a write to 0x8 -> hready=1, hresp=00, hrdata=0; reading 0x8 afterwards returns RST_VAL.
- Basic write/read, WAIT_CNT=2: write 0xDEADBEEF to 0x4, then read 0x4 -> each data phase has 2 cycles hready=0 then 1; read returns 0xDEADBEEF.
- Back-to-back with forwarding, WAIT_CNT=0: NONSEQ write 0x10=0x12345678 immediately followed by read 0x10 -> read completes next cycle with 0x12345678.
- Error paths:
  - Read 0x41 -> ERR1 (hready=0, hresp=01), then ERR2 (hready=1, hresp=01).
  - Write 0x40 (index 16) -> same two cycles; no register changes.
- IDLE/BUSY: htrans=01 with hsel=1, then hsel=0 with htrans=10 -> hready stays 1, hresp 00, no state change.
- With AHB_SLV_PROT_CHK_EN: write 0x0 with hprot=4'b0001 -> two-cycle ERROR, reg0 unchanged; hprot=4'b0011 -> OKAY, write takes effect.
